// File: rtl/dwf_sign_restore.sv
// Sign restore stage: rebuilds a saturating two's-complement word from magnitude and sign,
// registered behind a single-entry valid/ready pipeline with a saturation event counter.
module dwf_sign_restore #(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     mag,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     opb,
  output logic             sat,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             cnt_clr
);

  logic             accept;
  logic [N-1:0]     conv_opb;
  logic             conv_sat;
  logic [CNT_W-1:0] cnt_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Positive overflow is any magnitude with the top bit set; negative overflow
  // needs the top bit plus any lower bit, since exactly 2^(N-1) maps to MINN.
  always_comb begin
    conv_opb = '0;
    conv_sat = 1'b0;
    if (!sign) begin
      if (mag[N-1]) begin
        conv_opb = {1'b0, {(N-1){1'b1}}};
        conv_sat = 1'b1;
      end else begin
        conv_opb = mag;
      end
    end else begin
      if (mag[N-1] && (|mag[N-2:0])) begin
        conv_opb = {1'b1, {(N-1){1'b0}}};
        conv_sat = 1'b1;
      end else begin
        conv_opb = (~mag) + 1'b1;
      end
    end
  end

  // Clear is applied first so a same-cycle saturating accept still counts.
  always_comb begin
    cnt_next = cnt_clr ? '0 : sat_cnt;
    if (accept && conv_sat && (cnt_next != '1))
      cnt_next = cnt_next + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      opb       <= '0;
      sat       <= 1'b0;
      sat_cnt   <= '0;
    end else begin
      sat_cnt <= cnt_next;
      if (accept) begin
        out_valid <= 1'b1;
        opb       <= conv_opb;
        sat       <= conv_sat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dwf_sign_restore.sv
// Randomized and directed bench for dwf_sign_restore against a queue-based
// reference model using signed integer arithmetic with clamping.
module tb_dwf_sign_restore;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] mag;
  logic       sign;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] opb;
  logic       sat;
  logic [7:0] sat_cnt;
  logic       cnt_clr;

  int errors = 0;
  int checks = 0;

  logic [8:0] q[$];   // {sat, opb} words accepted but not yet transferred
  int         mcnt;

  dwf_sign_restore #(.N(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mag(mag), .sign(sign), .out_valid(out_valid), .out_ready(out_ready),
    .opb(opb), .sat(sat), .sat_cnt(sat_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ref_conv(input logic [7:0] m, input logic s);
    int v;
    logic is_sat;
    logic [7:0] r;
    v = s ? -int'(m) : int'(m);
    is_sat = 1'b0;
    if (v > 127)  begin v = 127;  is_sat = 1'b1; end
    if (v < -128) begin v = -128; is_sat = 1'b1; end
    r = v[7:0];
    return {is_sat, r};
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, ".opb"}, 32'(opb), 32'(q[0][7:0]));
      chk({tag, ".sat"}, 32'(sat), 32'(q[0][8]));
    end
    chk({tag, ".sat_cnt"}, 32'(sat_cnt), 32'(mcnt));
  endtask

  task automatic step(input logic iv, input logic [7:0] m, input logic s,
                      input logic ordy, input logic clr, input string tag);
    logic exp_rdy, acc, xfer;
    logic [8:0] w;
    @(negedge clk);
    in_valid = iv; mag = m; sign = s; out_ready = ordy; cnt_clr = clr; rst = 1'b0;
    #1;
    exp_rdy = (q.size() == 0) || ordy;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    acc  = iv && exp_rdy;
    xfer = (q.size() != 0) && ordy;
    w    = ref_conv(m, s);
    @(posedge clk);
    #1;
    if (xfer) void'(q.pop_front());
    if (acc) q.push_back(w);
    if (clr) mcnt = 0;
    if (acc && w[8] && mcnt < 255) mcnt++;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; mag = 8'hFF; sign = 1'b0; cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    mcnt = 0;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".opb"}, 32'(opb), 32'd0);
    chk({tag, ".sat"}, 32'(sat), 32'd0);
    chk({tag, ".sat_cnt"}, 32'(sat_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mag = '0; sign = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    mcnt = 0;
    do_reset("reset");

    // basic conversion
    step(1, 8'd7, 0, 1, 0, "t1a");
    step(1, 8'd7, 1, 1, 0, "t1b");
    chk("t1b.opb_literal", 32'(opb), 32'h F9);
    step(1, 8'h80, 1, 1, 0, "t2a");
    step(1, 8'h80, 0, 1, 0, "t2b");
    step(1, 8'hFF, 1, 1, 0, "t2c");
    step(0, 8'h00, 0, 1, 0, "t2d");
    chk("t2.sat_cnt_literal", 32'(sat_cnt), 32'd2);
    step(1, 8'h00, 1, 1, 0, "t3");
    step(0, 8'h00, 0, 1, 0, "t3idle");

    // backpressure with streaming input
    begin
      logic [7:0] nxt;
      nxt = 8'h11;
      step(1, nxt, 0, 0, 0, "t4load");
      nxt++;
      for (int i = 0; i < 5; i++) begin
        step(1, nxt, 0, 0, 0, "t4hold");
        chk("t4.held_literal", 32'(opb), 32'h11);
      end
      for (int i = 0; i < 3; i++) begin
        step(1, nxt, 0, 1, 0, "t4rel");
        nxt++;
      end
      step(0, 8'h00, 0, 1, 0, "t4drain");
    end

    // counter saturation and clear-with-increment
    for (int i = 0; i < 300; i++)
      step(1, 8'($urandom_range(128, 255)), 1'($urandom), 1, 0, "t5sat");
    chk("t5.cnt_stuck", 32'(sat_cnt), 32'hFF);
    step(1, 8'hC0, 0, 1, 1, "t5clr");
    chk("t5.clr_literal", 32'(sat_cnt), 32'd1);
    step(1, 8'h05, 0, 1, 1, "t5clr_nosat");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [7:0] m;
      case ($urandom_range(0, 3))
        0: m = 8'($urandom_range(126, 130));
        1: m = 8'h00;
        default: m = 8'($urandom);
      endcase
      step(1'($urandom_range(0, 3) != 0), m, 1'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0), "rnd");
    end

    // reset while output is stalled
    step(1, 8'hFF, 0, 0, 0, "t6load");
    step(1, 8'h22, 0, 0, 0, "t6stall");
    do_reset("t6rst");
    step(1, 8'h33, 1, 1, 0, "t6after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
